io_port_bank_p: RTL

Parametrised memory-mapped I/O port bank that sits between the CPU data bus and the external port pins of the computer top level. It replaces fixed 16 x 8-bit port wiring with NUM_PORTS ports of DATA_W bits. Output ports are latched and readable back. Input ports pass through a two-flop synchroniser, are read through a registered path, and can flag value changes.

---
 rtl/io_port_bank_p.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/io_port_bank_p.sv
// io_port_bank_p: memory-mapped bank of NUM_PORTS output latches and NUM_PORTS
// synchronised input ports on a DATA_W-bit CPU bus. Output latches are readable
// back; input ports pass through a two-flop synchroniser before being read.
// Optional build macro IO_CHANGE_IRQ_EN adds per-port change flags, a
// status/clear register at IRQ_ADDR and the irq output (irq is tied 0 otherwise).
module io_port_bank_p #(
  parameter int unsigned       NUM_PORTS = 16,
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_OUT  = 'hE0,
  parameter logic [ADDR_W-1:0] BASE_IN   = 'hF0,
  parameter logic [ADDR_W-1:0] IRQ_ADDR  = 'hDF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           address,
  input  logic                        write,
  input  logic                        read,
  input  logic [DATA_W-1:0]           data_in,
  output logic [DATA_W-1:0]           data_out,
  input  logic [NUM_PORTS*DATA_W-1:0] port_in,
  output logic [NUM_PORTS*DATA_W-1:0] port_out,
  output logic                        irq
);

  localparam int unsigned     IDX_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_W:0] PORT_COUNT = (ADDR_W+1)'(NUM_PORTS);

`ifdef IO_CHANGE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  // Address windows in plain integers, used only for the configuration check.
  localparam int unsigned OUT_LO = 32'(BASE_OUT);
  localparam int unsigned IN_LO  = 32'(BASE_IN);
  localparam int unsigned IRQ_A  = 32'(IRQ_ADDR);
  localparam bit WIN_CLASH = (OUT_LO < IN_LO + NUM_PORTS) && (IN_LO < OUT_LO + NUM_PORTS);
  localparam bit IRQ_CLASH = IRQ_EN &&
                             (((IRQ_A >= OUT_LO) && (IRQ_A < OUT_LO + NUM_PORTS)) ||
                              ((IRQ_A >= IN_LO)  && (IRQ_A < IN_LO  + NUM_PORTS)));

  // Overlapping address windows would make the decode ambiguous.
  cfg_window_check: assert property (@(posedge clk) !(WIN_CLASH || IRQ_CLASH));

  logic [NUM_PORTS-1:0][DATA_W-1:0] out_q;
  logic [NUM_PORTS-1:0][DATA_W-1:0] sync1_q;
  logic [NUM_PORTS-1:0][DATA_W-1:0] sync2_q;

  logic [ADDR_W-1:0] out_off;
  logic [ADDR_W-1:0] in_off;
  logic              out_hit;
  logic              in_hit;
  logic [IDX_W-1:0]  out_sel;
  logic [IDX_W-1:0]  in_sel;
  logic [DATA_W-1:0] rd_data;

  // Offsets wrap in ADDR_W bits, so an address below a base looks huge and misses.
  assign out_off = address - BASE_OUT;
  assign in_off  = address - BASE_IN;
  assign out_hit = ({1'b0, out_off} < PORT_COUNT);
  assign in_hit  = ({1'b0, in_off} < PORT_COUNT);
  assign out_sel = out_off[IDX_W-1:0];
  assign in_sel  = in_off[IDX_W-1:0];

  assign port_out = out_q;

  // Output latches: load the addressed port on a CPU write.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      // NOTE: the latch array is a handful of flops that drive pins, so it is reset, unlike a RAM.
      out_q <= '0;
    end else if (write && out_hit) begin
      out_q[out_sel] <= data_in;
    end
  end

  // Two-flop synchroniser for the asynchronous input pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= port_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef IO_CHANGE_IRQ_EN
  logic [NUM_PORTS-1:0][DATA_W-1:0] prev_q;
  logic [NUM_PORTS-1:0]             flag_q;
  logic [NUM_PORTS-1:0]             flag_set;
  logic [NUM_PORTS-1:0]             flag_clr;
  logic                             irq_q;
  logic                             irq_hit;
  logic [DATA_W-2:0]                pend_idx;
  logic [DATA_W-1:0]                irq_status;

  assign irq_hit = (address == IRQ_ADDR);

  // Per-port set on a synchronised value change, clear on a write of the port index.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
    flag_set = '0;
    flag_clr = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      flag_set[i] = (sync2_q[i] != prev_q[i]);
      flag_clr[i] = write && irq_hit && (data_in == DATA_W'(i));
    end
  end

  // Lowest pending index: scan downwards so the smallest set flag wins.
  always_comb begin
    pend_idx = '0;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      if (flag_q[i]) pend_idx = (DATA_W-1)'(i);
    end
  end

  assign irq_status = (|flag_q) ? {1'b1, pend_idx} : '0;

  // Change history, sticky flags (set beats clear) and the registered interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
      flag_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= sync2_q;
      flag_q <= (flag_q & ~flag_clr) | flag_set;
      irq_q  <= |flag_q;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Read mux: unmapped addresses return zero.
  always_comb begin
    rd_data = '0;
    if (in_hit) begin
      rd_data = sync2_q[in_sel];
    end else if (out_hit) begin
      rd_data = out_q[out_sel];
    end
`ifdef IO_CHANGE_IRQ_EN
    else if (irq_hit) begin
      rd_data = irq_status;
    end
`endif
  end

  // Registered read port: updates only on a read strobe, holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
    end else if (read) begin
      data_out <= rd_data;
    end
  end

endmodule
